grf_scoreboard: RTL
===================

Name: grf_scoreboard

Overview:
- General register file with its hazard scoreboard. It sits at the D stage of the five-stage MIPS pipeline.
- Write side: it consumes the W-stage writeback (address, data, PC) and commits it to the 32x32 register array.
- Read side: it serves two D-stage read ports, with same-cycle write-to-read bypass.
- Per-register Tnew countdowns track in-flight producers; the block raises a stall when a D-stage source is not ready by its Tuse.

Parameters:
- DW, 32, data width of a register.
- AW, 5, register address width; the array holds 2**AW entries.
- DEPTH, 3, cycles from D-stage issue until the producer's W-stage write (E, M, W).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- w_en  in  1  W-stage register write enable.
- w_addr  in  AW  W-stage destination register.
- w_data  in  DW  W-stage writeback value (from the W-stage result mux).
- w_pc  in  32  PC of the writing instruction; used only by the trace feature.
- rs_addr  in  AW  D-stage source register rs.
- rt_addr  in  AW  D-stage source register rt.
- rs_used  in  1  D-stage instruction reads rs.
- rt_used  in  1  D-stage instruction reads rt.
- rs_tuse  in  2  cycles until rs is needed (0 = D, 1 = E, 2 = M).
- rt_tuse  in  2  cycles until rt is needed.
- iss_en  in  1  D-stage instruction advances into E this cycle.
- iss_dst  in  AW  destination register of the issuing instruction; 0 = none.
- iss_tnew  in  2  cycles, counted from E entry, until the result is forwardable.
- rs_data  out  DW  rs read value (combinational).
- rt_data  out  DW  rt read value (combinational).
- stall  out  1  freeze F/D, insert bubble into E (combinational).

Behaviour:
- Reset (async, reset_n = 0):
  - All array entries clear to 0.
  - All age and tnew counters clear to 0; no register is busy.
  - stall = 0 while in reset, because no register is busy.
  - Reset mid-operation discards all in-flight scoreboard state immediately.
- Array write, at posedge:
  - If w_en and w_addr != 0, then mem[w_addr] <= w_data.
  - A write to register 0 is dropped.
- Read, combinational, evaluated independently for rs and rt:
  - addr == 0: output 0.
  - Else if w_en and w_addr == addr: output w_data (same-cycle bypass).
  - Else: output mem[addr].
  - Read latency is 0 cycles.
- Scoreboard state, per register r != 0:
  - age[r], 2 bits: cycles left until the producer's write.
  - tnew[r], 2 bits: cycles left until the result is forwardable.
  - busy[r] = (age[r] != 0).
- Issue: let issue = iss_en & ~stall. An asserted iss_en while stall = 1 is ignored.
- At each posedge, per register r != 0:
  - If issue and iss_dst == r: age[r] <= DEPTH and tnew[r] <= iss_tnew. The newest producer overrides any older one.
  - Else: age[r] decrements, saturating at 0; tnew[r] decrements, saturating at 0.
  - iss_dst == 0 records nothing.
  - w_en does not touch the scoreboard. Aging alone retires entries, which keeps in-order multiple writers to the same register correct.
- Stall, combinational:
  - stall = (rs_used & rs_addr != 0 & busy[rs] & tnew[rs] > rs_tuse) | the same term for rt.
  - Comparison is unsigned 2-bit.
- Simultaneous issue and W write to the same register: the array takes w_data; the scoreboard takes the new issue.
- iss_tnew values above DEPTH-1 are clamped to DEPTH-1.

Optional Feature:
- GRF_TRACE_EN defined: on each committed write (w_en & w_addr != 0), at posedge, print "@%h: $%d <= %h" with w_pc, w_addr and w_data. Simulation only.
- GRF_TRACE_EN not defined: no display logic. w_pc is left unconnected internally; the port remains, so the interface is unchanged.

Decomposition:
- Shared package:
  - Tuse/Tnew encodings: TUSE_D = 0, TUSE_E = 1, TUSE_M = 2; TNEW_E = 1, TNEW_M = 2.
  - REG_ZERO = 0.
  - PIPE_DEPTH = 3.
- One sub-module, grf_sb_entry: the per-register age/tnew counter pair with load/decrement logic. It is instantiated 2**AW - 1 times via generate.
- The array and the read bypass stay in the top module.

Test Plan:
- Reset, then read rs = 5, rt = 0 -> rs_data = 0, rt_data = 0, stall = 0.
- w_en = 1, w_addr = 8, w_data = 0x1234, with rs_addr = 8 in the same cycle -> rs_data = 0x1234 in that cycle. Next cycle, with w_en = 0 -> still 0x1234.
- Load-use:
  - Issue dst = 9, tnew = 2.
  - Next cycle, rs_used = 1, rs_addr = 9, rs_tuse = 1 (ALU) -> stall = 1 for exactly 1 cycle.
  - Then stall = 0 (tnew = 1, which is not > 1).
- Branch source:
  - Issue dst = 3, tnew = 1.
  - Next cycle, rt_used = 1, rt_addr = 3, rt_tuse = 0 -> stall = 1 for 1 cycle.
- Write to register 0:
  - w_en = 1, w_addr = 0, w_data = 0xFFFFFFFF -> reading register 0 returns 0.
  - Issue dst = 0 -> no stall on a subsequent reader of register 0.
- Mid-flight reset:
  - Issue dst = 7, tnew = 2, then pulse reset_n low mid-cycle -> stall = 0 immediately.
  - Register 7 reads 0 after reset.

Source files
------------

// File: rtl/grf_scoreboard_pkg.sv
// Shared definitions for the D-stage register file and its hazard scoreboard.
// Contents:
//   TUSE_* / TNEW_*  : stage encodings for operand need time and result readiness
//   REG_ZERO         : hard-wired zero register index
//   PIPE_DEPTH       : cycles from D-stage issue until the W-stage write (E, M, W)
//   sb_state_t       : per-register age/tnew counter pair
//   clamp_tnew       : limits a producer's Tnew to what the pipe can express
//   sat_dec          : 2-bit decrement that sticks at zero
package grf_scoreboard_pkg;

    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;
    localparam logic [1:0] TNEW_E = 2'd1;
    localparam logic [1:0] TNEW_M = 2'd2;

    localparam int REG_ZERO   = 0;
    localparam int PIPE_DEPTH = 3;

    typedef struct packed {
        logic [1:0] age;
        logic [1:0] tnew;
    } sb_state_t;

    // A result can never become forwardable later than the cycle before it
    // is written back, so anything larger is pulled down to depth-1.
    function automatic logic [1:0] clamp_tnew(input logic [1:0] tnew, input int depth);
        if (int'(tnew) > depth - 1) begin
            return 2'(depth - 1);
        end
        return tnew;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] value);
        return (value != 2'd0) ? value - 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/grf_sb_entry.sv
// One scoreboard slot: tracks the youngest in-flight producer of a register.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : the issuing instruction writes this register
//   load_tnew    : Tnew of that instruction (clamped on load)
//   busy         : a producer has not yet written back
//   tnew         : cycles left until the result is forwardable
module grf_sb_entry
    import grf_scoreboard_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [1:0] load_tnew,
    output logic       busy,
    output logic [1:0] tnew
);

    sb_state_t state;

    // A new load always wins over the running countdown: in-order issue means
    // the newest producer is the one a later reader must wait for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
        end else if (load) begin
            state.age  <= 2'(DEPTH);
            state.tnew <= clamp_tnew(load_tnew, DEPTH);
        end else begin
            state.age  <= sat_dec(state.age);
            state.tnew <= sat_dec(state.tnew);
        end
    end

    assign busy = (state.age != 2'd0);
    assign tnew = state.tnew;

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with hazard scoreboard for the D stage of a five-stage
// MIPS pipeline. Commits W-stage writebacks, serves two combinational read
// ports with same-cycle write bypass, and raises stall when a D-stage source
// will not be forwardable by the time it is needed.
// Ports:
//   clk, reset_n             : clock and asynchronous active-low reset
//   w_en/w_addr/w_data/w_pc  : W-stage writeback (w_pc only feeds the trace)
//   rs_addr/rt_addr          : D-stage source registers
//   rs_used/rt_used          : the D-stage instruction actually reads the source
//   rs_tuse/rt_tuse          : cycles until the source value is needed
//   iss_en/iss_dst/iss_tnew  : instruction leaving D for E and its result timing
//   rs_data/rt_data          : read values (combinational)
//   stall                    : freeze F/D and bubble E (combinational)
// Build option: define GRF_TRACE_EN to print every committed write.
module grf_scoreboard
    import grf_scoreboard_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          w_en,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic [31:0]   w_pc,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          rs_used,
    input  logic          rt_used,
    input  logic [1:0]    rs_tuse,
    input  logic [1:0]    rt_tuse,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_dst,
    input  logic [1:0]    iss_tnew,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          stall
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DW-1:0]       mem [0:NREG-1];
    logic [NREG-1:0]     busy_vec;
    logic [NREG-1:0][1:0] tnew_vec;
    logic                rs_hazard;
    logic                rt_hazard;
    logic                issue;
    logic                w_commit;

    assign w_commit = w_en && (w_addr != ZERO_ADDR);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (w_commit) begin
            mem[w_addr] <= w_data;
        end
    end

    // The bypass lets a D-stage reader see the value W commits at this edge.
    always_comb begin
        rs_data = mem[rs_addr];
        if (rs_addr == ZERO_ADDR) begin
            rs_data = '0;
        end else if (w_en && (w_addr == rs_addr)) begin
            rs_data = w_data;
        end
    end

    always_comb begin
        rt_data = mem[rt_addr];
        if (rt_addr == ZERO_ADDR) begin
            rt_data = '0;
        end else if (w_en && (w_addr == rt_addr)) begin
            rt_data = w_data;
        end
    end

    // Register 0 has no scoreboard slot; it is never busy.
    assign busy_vec[0] = 1'b0;
    assign tnew_vec[0] = 2'd0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        grf_sb_entry #(
            .DEPTH(DEPTH)
        ) u_entry (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (issue && (iss_dst == AW'(r))),
            .load_tnew(iss_tnew),
            .busy     (busy_vec[r]),
            .tnew     (tnew_vec[r])
        );
    end

    assign rs_hazard = rs_used && (rs_addr != ZERO_ADDR) && busy_vec[rs_addr]
                       && (tnew_vec[rs_addr] > rs_tuse);
    assign rt_hazard = rt_used && (rt_addr != ZERO_ADDR) && busy_vec[rt_addr]
                       && (tnew_vec[rt_addr] > rt_tuse);
    assign stall     = rs_hazard || rt_hazard;

    // A stalled instruction stays in D, so its issue request must not record.
    assign issue = iss_en && !stall;

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset_n && w_commit) begin
            $display("@%h: $%d <= %h", w_pc, w_addr, w_data);
        end
    end
`else
    logic unused_w_pc;
    assign unused_w_pc = ^w_pc;
`endif

endmodule
